// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared widths, reset PC and FSM encoding for the IF fetch sequencer
package if_fetch_ctrl_pkg;

    localparam int          IF_XLEN     = 64;
    localparam int          IF_INST_W   = 32;
    localparam logic [63:0] IF_PC_START = 64'h8000_0000;

    typedef enum logic [1:0] {
        IF_ST_IDLE = 2'd0,
        IF_ST_REQ  = 2'd1,
        IF_ST_WAIT = 2'd2,
        IF_ST_HALT = 2'd3
    } if_state_e;

    function automatic logic pc_is_misal(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_out_buf.sv
// rtl/if_out_buf.sv - one-entry IF->ID buffer with valid/allowin handshake and flush
module if_out_buf
    import if_fetch_ctrl_pkg::*;
#(
    parameter int XLEN = IF_XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [XLEN-1:0]      wr_pc_i,
    input  logic [IF_INST_W-1:0] wr_inst_i,
    input  logic                 wr_misal_i,
    input  logic                 rd_ready_i,
    output logic                 valid_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [IF_INST_W-1:0] inst_o,
    output logic                 misal_o
);

    logic                 valid_q;
    logic [XLEN-1:0]      pc_q;
    logic [IF_INST_W-1:0] inst_q;
    logic                 misal_q;

    // Flush beats both a refill and a drain; payload is only meaningful while valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            misal_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
            pc_q    <= wr_pc_i;
            inst_q  <= wr_inst_i;
            misal_q <= wr_misal_i;
        end else if (valid_q && rd_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign misal_o = misal_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF fetch sequencer: next-PC select, single-outstanding imem port, stale-response drop
// Optional misaligned-PC fault entry and HALT state enabled by IF_MISAL_EXCP_EN.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = IF_XLEN,
    parameter logic [XLEN-1:0] PC_START = IF_PC_START
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_allowin,
    input  logic                 bj_ena,
    input  logic [XLEN-1:0]      new_pc,
    input  logic                 excp_jmp_ena,
    input  logic [XLEN-1:0]      excp_pc,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [IF_INST_W-1:0] imem_rdata,
    output logic                 if_id_valid,
    output logic [XLEN-1:0]      if_pc,
    output logic [IF_INST_W-1:0] if_inst,
    output logic                 if_excp_misal
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;

    logic            redirect;
    logic [XLEN-1:0] redir_pc;
    logic            buf_free;
    logic            grant;
    logic            misal_pc;
    logic            buf_wr;
    logic            buf_misal;

    assign redirect  = excp_jmp_ena | bj_ena;
    assign redir_pc  = excp_jmp_ena ? excp_pc : new_pc;
    assign buf_free  = !if_id_valid || id_allowin;
    assign grant     = imem_req && imem_gnt;
    assign imem_addr = pc_q;

`ifdef IF_MISAL_EXCP_EN
    assign misal_pc = pc_is_misal(pc_q[1:0]);
`else
    assign misal_pc = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_ST_IDLE;
            pc_q    <= PC_START;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        imem_req  = 1'b0;
        buf_wr    = 1'b0;
        buf_misal = 1'b0;
        case (state_q)
            IF_ST_IDLE: state_d = IF_ST_REQ;
            IF_ST_REQ: begin
                imem_req = buf_free && !misal_pc;
                if (grant) begin
                    state_d = IF_ST_WAIT;
                    drop_d  = redirect;
                end else if (misal_pc && buf_free && !redirect) begin
                    buf_wr    = 1'b1;
                    buf_misal = 1'b1;
                    state_d   = IF_ST_HALT;
                end
            end
            IF_ST_WAIT: begin
                // A redirect coinciding with rvalid kills that response directly, so drop is never armed.
                if (imem_rvalid) begin
                    state_d = IF_ST_REQ;
                    drop_d  = 1'b0;
                    if (!drop_q && !redirect) begin
                        buf_wr = 1'b1;
                        pc_d   = pc_q + XLEN'(4);
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            IF_ST_HALT: begin
                if (redirect) state_d = IF_ST_REQ;
            end
            default: state_d = IF_ST_IDLE;
        endcase
        if (redirect) pc_d = redir_pc;
    end

    if_out_buf #(.XLEN(XLEN)) u_out_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect),
        .wr_en_i    (buf_wr),
        .wr_pc_i    (pc_q),
        .wr_inst_i  (buf_misal ? '0 : imem_rdata),
        .wr_misal_i (buf_misal),
        .rd_ready_i (id_allowin),
        .valid_o    (if_id_valid),
        .pc_o       (if_pc),
        .inst_o     (if_inst),
        .misal_o    (if_excp_misal)
    );

endmodule
